// File: rtl/wb_host_loader_pkg.sv
// Shared constants and types for the host-link Wishbone loader:
// command opcodes, fixed response bytes, bus widths and FSM states.
package wb_host_loader_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 8;

  localparam logic [7:0] OP_SETADDR = 8'h01;
  localparam logic [7:0] OP_WRITE   = 8'h02;
  localparam logic [7:0] OP_READ    = 8'h03;
  localparam logic [7:0] OP_PING    = 8'h04;
  localparam logic [7:0] OP_STATUS  = 8'h05;

  localparam logic [7:0] PING_RESP    = 8'hA5;
  // Byte returned for a read whose bus cycle was abandoned.
  localparam logic [7:0] TIMEOUT_RESP = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_WDATA,
    ST_WB_WR,
    ST_WB_RD,
    ST_RSP
  } state_t;

endpackage

// File: rtl/wb_host_loader_if.sv
// Bundles the host command/response byte streams and the Wishbone
// initiator bus. "master" is the loader's view, "slave" is the view of
// whatever sits on the other side (host front end plus bus fabric).
interface wb_host_loader_if;
  import wb_host_loader_pkg::*;

  logic [DATA_W-1:0] cmd_data;
  logic              cmd_valid;
  logic              cmd_ready;

  logic [DATA_W-1:0] rsp_data;
  logic              rsp_valid;
  logic              rsp_ready;

  // Bit 0 of the mainboard's MSB-first numbering is bit 23 here.
  logic [ADDR_W-1:0] wb_adr_o;
  logic [DATA_W-1:0] wb_dat_o;
  logic [DATA_W-1:0] wb_dat_i;
  logic              wb_we_o;
  logic              wb_sel_o;
  logic              wb_stb_o;
  logic              wb_cyc_o;
  logic              wb_ack_i;

  modport master (
    input  cmd_data, cmd_valid, rsp_ready, wb_dat_i, wb_ack_i,
    output cmd_ready, rsp_data, rsp_valid,
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );

  modport slave (
    output cmd_data, cmd_valid, rsp_ready, wb_dat_i, wb_ack_i,
    input  cmd_ready, rsp_data, rsp_valid,
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );

endinterface

// File: rtl/wb_host_loader.sv
// Host-link to Wishbone loader. Parses a byte-stream command channel,
// issues single-byte classic Wishbone cycles with address auto-increment
// and returns read data / status bytes on a byte-stream response channel.
// A cycle that is not acknowledged within TIMEOUT_CYCLES is abandoned,
// flagged in the sticky timeout_err and (for reads) answered with 0xFF.
module wb_host_loader
  import wb_host_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             reset_n,
  wb_host_loader_if.master bus,
  output logic             busy,
  output logic             timeout_err
);

  // Counter only has to reach TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES >= 2).
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        op_reg, op_next;
  logic [1:0]        addr_idx_reg, addr_idx_next;
  logic [7:0]        len_reg, len_next;
  logic [TW-1:0]     tmo_reg, tmo_next;
  logic              stb_reg, stb_next;
  logic              we_reg, we_next;
  logic [DATA_W-1:0] dat_reg, dat_next;
  logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
  logic              terr_reg, terr_next;
  logic              xfer_done;

  // A transfer ends on an acknowledge or when the wait budget runs out.
  assign xfer_done = stb_reg && (bus.wb_ack_i || (tmo_reg == TMO_LAST));

  // State and datapath registers; reset drops the bus cycle immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      op_reg       <= '0;
      addr_idx_reg <= '0;
      len_reg      <= '0;
      tmo_reg      <= '0;
      stb_reg      <= 1'b0;
      we_reg       <= 1'b0;
      dat_reg      <= '0;
      rsp_data_reg <= '0;
      terr_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      op_reg       <= op_next;
      addr_idx_reg <= addr_idx_next;
      len_reg      <= len_next;
      tmo_reg      <= tmo_next;
      stb_reg      <= stb_next;
      we_reg       <= we_next;
      dat_reg      <= dat_next;
      rsp_data_reg <= rsp_data_next;
      terr_reg     <= terr_next;
    end
  end

  // Command parsing, bus sequencing and next-value computation.
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    op_next       = op_reg;
    addr_idx_next = addr_idx_reg;
    len_next      = len_reg;
    tmo_next      = tmo_reg;
    stb_next      = stb_reg;
    we_next       = we_reg;
    dat_next      = dat_reg;
    rsp_data_next = rsp_data_reg;
    terr_next     = terr_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_next = bus.cmd_data;
          case (bus.cmd_data)
            OP_SETADDR: begin
              addr_idx_next = 2'd0;
              state_next    = ST_ADDR;
            end
            OP_WRITE, OP_READ: state_next = ST_LEN;
            OP_PING: begin
              rsp_data_next = PING_RESP;
              state_next    = ST_RSP;
            end
            OP_STATUS: begin
              rsp_data_next = {7'b0, terr_reg};
              terr_next     = 1'b0;
              state_next    = ST_RSP;
            end
            default: ; // unknown opcode: swallow the byte
          endcase
        end
      end

      ST_ADDR: begin
        // Address arrives MSB first, so shift each byte in from the right.
        if (bus.cmd_valid) begin
          addr_next     = {addr_reg[ADDR_W-9:0], bus.cmd_data};
          addr_idx_next = addr_idx_reg + 2'd1;
          if (addr_idx_reg == 2'd2) state_next = ST_IDLE;
        end
      end

      ST_LEN: begin
        // len_reg holds "transfers remaining minus one".
        if (bus.cmd_valid) begin
          len_next = bus.cmd_data;
          if (op_reg == OP_WRITE) begin
            state_next = ST_WDATA;
          end else begin
            stb_next   = 1'b1;
            we_next    = 1'b0;
            tmo_next   = '0;
            state_next = ST_WB_RD;
          end
        end
      end

      ST_WDATA: begin
        if (bus.cmd_valid) begin
          dat_next   = bus.cmd_data;
          we_next    = 1'b1;
          stb_next   = 1'b1;
          tmo_next   = '0;
          state_next = ST_WB_WR;
        end
      end

      ST_WB_WR, ST_WB_RD: begin
        if (xfer_done) begin
          stb_next  = 1'b0;
          we_next   = 1'b0;
          addr_next = addr_reg + 24'd1;
          if (!bus.wb_ack_i) terr_next = 1'b1;
          if (state_reg == ST_WB_RD) begin
            rsp_data_next = bus.wb_ack_i ? bus.wb_dat_i : TIMEOUT_RESP;
            state_next    = ST_RSP;
          end else if (len_reg == 8'd0) begin
            state_next = ST_IDLE;
          end else begin
            len_next   = len_reg - 8'd1;
            state_next = ST_WDATA;
          end
        end else if (stb_reg) begin
          tmo_next = tmo_reg + TW'(1);
        end
      end

      ST_RSP: begin
        // Next read of a burst is only launched once the host took the byte.
        if (bus.rsp_ready) begin
          if ((op_reg == OP_READ) && (len_reg != 8'd0)) begin
            len_next   = len_reg - 8'd1;
            stb_next   = 1'b1;
            we_next    = 1'b0;
            tmo_next   = '0;
            state_next = ST_WB_RD;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_reg inside {ST_IDLE, ST_ADDR, ST_LEN, ST_WDATA});
  assign bus.rsp_valid = (state_reg == ST_RSP);
  assign bus.rsp_data  = rsp_data_reg;

  assign bus.wb_adr_o  = addr_reg;
  assign bus.wb_dat_o  = dat_reg;
  assign bus.wb_we_o   = we_reg;
  assign bus.wb_stb_o  = stb_reg;
  assign bus.wb_cyc_o  = stb_reg;
  assign bus.wb_sel_o  = stb_reg;

  assign busy        = (state_reg != ST_IDLE);
  assign timeout_err = terr_reg;

endmodule

// File: tb/tb_wb_host_loader.sv
// Bench for wb_host_loader: a Wishbone slave model with programmable wait
// states, a scoreboard of expected bus transfers and response bytes, a
// table of single-transfer vectors and hand-written multi-cycle sequences.
module tb_wb_host_loader;

  logic clk = 1'b0;
  logic reset_n;
  logic busy;
  logic timeout_err;

  wb_host_loader_if bus();

  wb_host_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [23:0] adr;
    logic [7:0]  dat;
  } wb_t;

  typedef struct {
    logic        we;
    logic [23:0] adr;
    logic [7:0]  dat;
    int          ws;
  } vec_t;

  wb_t        wb_q[$];
  logic [7:0] rsp_q[$];
  wb_t        mon_e;
  logic [7:0] mon_r;

  int n_cmp = 0;
  int n_bad = 0;

  // Slave model state
  int   ws_cfg = 0;
  int   ws_cnt = 0;
  logic ack_en = 1'b1;

  // Observation counters
  int   xfer_cnt = 0;
  int   stb_rises = 0;
  int   stb_run = 0;
  int   gap_run = 0;
  int   last_gap = 0;
  int   last_stb_len = 0;
  logic prev_stb = 1'b0;

  function automatic logic [7:0] rd_fn(input logic [23:0] a);
    return a[23:16] ^ a[15:8] ^ a[7:0] ^ 8'h3C;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Slave: acknowledge after ws_cfg wait states, read data derived from address.
  assign bus.wb_ack_i = bus.wb_stb_o && ack_en && (ws_cnt == ws_cfg);
  assign bus.wb_dat_i = rd_fn(bus.wb_adr_o);

  always @(posedge clk) begin
    if (bus.wb_stb_o && !bus.wb_ack_i) ws_cnt <= ws_cnt + 1;
    else ws_cnt <= 0;
  end

  // Monitor, sampled on the falling edge: bus transfers, responses, stb shape.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.wb_stb_o && bus.wb_ack_i) begin
          xfer_cnt++;
          $display("wb %s adr=%06h dat=%02h", bus.wb_we_o ? "wr" : "rd", bus.wb_adr_o,
                   bus.wb_we_o ? bus.wb_dat_o : bus.wb_dat_i);
          if (wb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL wb_unexpected: got transfer at %06h, expected none", bus.wb_adr_o);
          end else begin
            mon_e = wb_q.pop_front();
            check("wb_we", bus.wb_we_o, mon_e.we);
            check("wb_adr", bus.wb_adr_o, mon_e.adr);
            if (mon_e.we) check("wb_dat", bus.wb_dat_o, mon_e.dat);
            check("wb_cyc", bus.wb_cyc_o, 1);
            check("wb_sel", bus.wb_sel_o, 1);
          end
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
          $display("rsp %02h", bus.rsp_data);
          if (rsp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_unexpected: got %02h, expected none", bus.rsp_data);
          end else begin
            mon_r = rsp_q.pop_front();
            check("rsp_data", bus.rsp_data, mon_r);
          end
        end
      end
      if (bus.wb_stb_o) begin
        if (!prev_stb) begin
          last_gap = gap_run;
          stb_rises++;
        end
        stb_run++;
        gap_run = 0;
      end else begin
        if (prev_stb) last_stb_len = stb_run;
        stb_run = 0;
        gap_run++;
      end
      prev_stb = bus.wb_stb_o;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    bus.cmd_data  = b;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    while (!bus.cmd_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_accept: byte %02h not accepted, cmd_ready=%0b expected 1", b, bus.cmd_ready);
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic set_addr(input logic [23:0] a);
    send_byte(8'h01);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic push_wr(input logic [23:0] a, input logic [7:0] d);
    wb_t e;
    e.we = 1'b1; e.adr = a; e.dat = d;
    wb_q.push_back(e);
  endtask

  task automatic push_rd(input logic [23:0] a);
    wb_t e;
    e.we = 1'b0; e.adr = a; e.dat = 8'h00;
    wb_q.push_back(e);
    rsp_q.push_back(rd_fn(a));
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_idle: busy=%0b after %0d clks, expected 0", tag, busy, guard);
    end
    check({tag, "_wbq_left"}, wb_q.size(), 0);
    check({tag, "_rspq_left"}, rsp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    check({tag, "_stb"}, bus.wb_stb_o, 0);
    check({tag, "_cyc"}, bus.wb_cyc_o, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_adr"}, bus.wb_adr_o, 0);
    wb_q.delete();
    rsp_q.delete();
    bus.cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  vec_t vecs[6];

  initial begin
    int r0;
    int x0;
    vecs[0] = '{we: 1'b1, adr: 24'h000100, dat: 8'h5A, ws: 0};
    vecs[1] = '{we: 1'b0, adr: 24'h000100, dat: 8'h00, ws: 0};
    vecs[2] = '{we: 1'b1, adr: 24'h800001, dat: 8'hC6, ws: 2};
    vecs[3] = '{we: 1'b0, adr: 24'hABCDEF, dat: 8'h00, ws: 1};
    vecs[4] = '{we: 1'b0, adr: 24'h000000, dat: 8'h00, ws: 5};
    vecs[5] = '{we: 1'b1, adr: 24'h7FFFFF, dat: 8'h01, ws: 0};

    reset_n       = 1'b0;
    bus.cmd_data  = 8'h00;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stb", bus.wb_stb_o, 0);
    check("rst_cyc", bus.wb_cyc_o, 0);
    check("rst_we", bus.wb_we_o, 0);
    check("rst_sel", bus.wb_sel_o, 0);
    check("rst_adr", bus.wb_adr_o, 0);
    check("rst_dat", bus.wb_dat_o, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_terr", timeout_err, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Burst write with zero-wait ack: one idle clock between strobes.
    ws_cfg = 0;
    set_addr(24'h123456);
    r0 = stb_rises;
    push_wr(24'h123456, 8'hAA);
    push_wr(24'h123457, 8'hBB);
    send_byte(8'h02); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
    wait_idle("t1");
    check("t1_stb_count", stb_rises - r0, 2);
    check("t1_idle_gap", last_gap, 1);

    // Read burst across the 24-bit address wrap.
    set_addr(24'hFFFFFF);
    push_rd(24'hFFFFFF);
    push_rd(24'h000000);
    send_byte(8'h03); send_byte(8'h01);
    wait_idle("t2");

    // Response backpressure: data held, no second read until accepted.
    ws_cfg = 1;
    set_addr(24'h000010);
    bus.rsp_ready = 1'b0;
    push_rd(24'h000010);
    push_rd(24'h000011);
    send_byte(8'h03); send_byte(8'h01);
    begin
      int guard = 0;
      while (!bus.rsp_valid && guard < 200) begin
        @(negedge clk);
        guard++;
      end
    end
    r0 = stb_rises;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t3_rsp_valid_held", bus.rsp_valid, 1);
      check("t3_rsp_data_held", bus.rsp_data, rd_fn(24'h000010));
    end
    check("t3_no_stb_while_held", stb_rises - r0, 0);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    wait_idle("t3");
    check("t3_second_stb", stb_rises - r0, 1);

    // Table of single transfers with varied wait states.
    for (int i = 0; i < 6; i++) begin
      ws_cfg = vecs[i].ws;
      set_addr(vecs[i].adr);
      if (vecs[i].we) begin
        push_wr(vecs[i].adr, vecs[i].dat);
        send_byte(8'h02); send_byte(8'h00); send_byte(vecs[i].dat);
      end else begin
        push_rd(vecs[i].adr);
        send_byte(8'h03); send_byte(8'h00);
      end
      wait_idle($sformatf("vec%0d", i));
    end

    // Unknown opcode is swallowed, then a ping still answers.
    rsp_q.push_back(8'hA5);
    send_byte(8'h7E); send_byte(8'h04);
    wait_idle("badop");

    // Timeout: no ack, strobe held exactly 16 clocks, read answers FF.
    ws_cfg = 0;
    ack_en = 1'b0;
    set_addr(24'h000050);
    rsp_q.push_back(8'hFF);
    send_byte(8'h03); send_byte(8'h00);
    wait_idle("t4");
    check("t4_stb_len", last_stb_len, 16);
    check("t4_terr_set", timeout_err, 1);
    ack_en = 1'b1;
    rsp_q.push_back(8'h01);
    send_byte(8'h05);
    wait_idle("t4_status1");
    check("t4_terr_cleared", timeout_err, 0);
    rsp_q.push_back(8'h00);
    send_byte(8'h05);
    wait_idle("t4_status0");
    push_rd(24'h000051);
    send_byte(8'h03); send_byte(8'h00);
    wait_idle("t4_addr_inc");

    // 256-byte write with 3 wait states.
    ws_cfg = 3;
    set_addr(24'h020000);
    x0 = xfer_cnt;
    send_byte(8'h02); send_byte(8'hFF);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] d;
      d = 8'(i) ^ 8'h96;
      push_wr(24'h020000 + 24'(i), d);
      send_byte(d);
    end
    wait_idle("t5");
    check("t5_xfer_count", xfer_cnt - x0, 256);
    check("t5_terr", timeout_err, 0);
    push_rd(24'h020100);
    send_byte(8'h03); send_byte(8'h00);
    wait_idle("t5_next_addr");

    // Reset while a response is pending.
    ws_cfg = 0;
    bus.rsp_ready = 1'b0;
    send_byte(8'h04);
    @(negedge clk);
    check("t6_rsp_pending", bus.rsp_valid, 1);
    @(posedge clk);
    #1;
    do_reset("t6a");
    bus.rsp_ready = 1'b1;

    // Reset with strobe high in the middle of a write burst.
    ws_cfg = 3;
    set_addr(24'h000400);
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h11);
    check("t6_stb_before_reset", bus.wb_stb_o, 1);
    do_reset("t6b");
    ws_cfg = 0;
    rsp_q.push_back(8'hA5);
    send_byte(8'h04);
    wait_idle("t6_ping");
    push_rd(24'h000000);
    send_byte(8'h03); send_byte(8'h00);
    wait_idle("t6_read0");
    check("t6_terr", timeout_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global bound so a stuck design cannot hang the run.
  initial begin
    #400000;
    n_bad++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
